// File: rtl/ram_dp_arbiter_1024_64.sv
// Two-client front end for a simple dual-port RAM: independent round-robin arbiters on the
// write and read ports, read data return one cycle after grant, optional zero-fill after reset.
module ram_dp_arbiter_1024_64 #(
    parameter int unsigned RAM_WIDTH      = 64,
    parameter int unsigned RAM_ADDR       = 10,
    parameter int unsigned RAM_DEPTH      = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 c0_req,
    input  logic                 c0_wr,
    input  logic [RAM_ADDR-1:0]  c0_addr,
    input  logic [RAM_WIDTH-1:0] c0_wdata,
    output logic                 c0_gnt,
    output logic                 c0_rvalid,
    output logic [RAM_WIDTH-1:0] c0_rdata,
    input  logic                 c1_req,
    input  logic                 c1_wr,
    input  logic [RAM_ADDR-1:0]  c1_addr,
    input  logic [RAM_WIDTH-1:0] c1_wdata,
    output logic                 c1_gnt,
    output logic                 c1_rvalid,
    output logic [RAM_WIDTH-1:0] c1_rdata,
    output logic                 init_done,
    output logic [RAM_ADDR-1:0]  ram_wr_addr,
    output logic [RAM_ADDR-1:0]  ram_rd_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic                 ram_write_en,
    output logic                 ram_read_en,
    output logic                 ram_chip_select,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(RAM_DEPTH - 1);

    state_t                 state_q;
    logic [RAM_ADDR-1:0]    clr_cnt_q;
    logic                   wptr_q;      // 0: c0 has priority, 1: c1 has priority
    logic                   rptr_q;
    logic                   rvalid0_q;
    logic                   rvalid1_q;
    logic                   init_done_q;
    logic [RAM_ADDR-1:0]    wr_addr_q;
    logic [RAM_ADDR-1:0]    rd_addr_q;
    logic [RAM_WIDTH-1:0]   wdata_q;

    logic                   run_c;
    logic                   clr_c;
    logic                   wcand0_c, wcand1_c, rcand0_c, rcand1_c;
    logic                   wg0_c, wg1_c, rs0_c, rs1_c, rg0_c, rg1_c;
    logic                   hazard_c;
    logic [RAM_ADDR-1:0]    wsel_addr_c;
    logic [RAM_WIDTH-1:0]   wsel_data_c;
    logic [RAM_ADDR-1:0]    rsel_addr_c;
    logic [RAM_ADDR-1:0]    wr_addr_d;
    logic [RAM_ADDR-1:0]    rd_addr_d;
    logic [RAM_WIDTH-1:0]   wdata_d;

    // Arbitration and RAM port steering; a write always beats a same-address read.
    always_comb begin
        run_c       = 1'b0;
        clr_c       = 1'b0;
        wcand0_c    = 1'b0;
        wcand1_c    = 1'b0;
        rcand0_c    = 1'b0;
        rcand1_c    = 1'b0;
        wg0_c       = 1'b0;
        wg1_c       = 1'b0;
        rs0_c       = 1'b0;
        rs1_c       = 1'b0;
        rg0_c       = 1'b0;
        rg1_c       = 1'b0;
        hazard_c    = 1'b0;
        wsel_addr_c = c0_addr;
        wsel_data_c = c0_wdata;
        rsel_addr_c = c0_addr;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wdata_d     = wdata_q;

        run_c    = (state_q == ST_RUN) && !reset;
        clr_c    = (state_q == ST_CLEAR) && !reset;
        wcand0_c = c0_req && c0_wr;
        wcand1_c = c1_req && c1_wr;
        rcand0_c = c0_req && !c0_wr;
        rcand1_c = c1_req && !c1_wr;

        wg0_c = run_c && wcand0_c && (!wcand1_c || !wptr_q);
        wg1_c = run_c && wcand1_c && (!wcand0_c || wptr_q);
        if (wg1_c) begin
            wsel_addr_c = c1_addr;
            wsel_data_c = c1_wdata;
        end

        rs0_c = run_c && rcand0_c && (!rcand1_c || !rptr_q);
        rs1_c = run_c && rcand1_c && (!rcand0_c || rptr_q);
        if (rs1_c) begin
            rsel_addr_c = c1_addr;
        end

        hazard_c = (wg0_c || wg1_c) && (rs0_c || rs1_c) && (rsel_addr_c == wsel_addr_c);
        rg0_c    = rs0_c && !hazard_c;
        rg1_c    = rs1_c && !hazard_c;

        if (clr_c) begin
            wr_addr_d = clr_cnt_q;
            wdata_d   = '0;
        end else if (wg0_c || wg1_c) begin
            wr_addr_d = wsel_addr_c;
            wdata_d   = wsel_data_c;
        end
        if (rg0_c || rg1_c) begin
            rd_addr_d = rsel_addr_c;
        end
    end

    assign c0_gnt          = wg0_c || rg0_c;
    assign c1_gnt          = wg1_c || rg1_c;
    assign ram_write_en    = clr_c || wg0_c || wg1_c;
    assign ram_read_en     = rg0_c || rg1_c;
    assign ram_chip_select = ram_write_en || ram_read_en;
    assign ram_wr_addr     = wr_addr_d;
    assign ram_rd_addr     = rd_addr_d;
    assign ram_data_in     = wdata_d;

    // A reset arriving while a read is in flight suppresses its rvalid immediately.
    assign c0_rvalid = rvalid0_q && !reset;
    assign c1_rvalid = rvalid1_q && !reset;
    assign c0_rdata  = ram_data_out;
    assign c1_rdata  = ram_data_out;
    assign init_done = init_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            init_done_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wdata_q     <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rg0_c;
            rvalid1_q <= rg1_c;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + RAM_ADDR'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                    // Priority passes to the client that was not just served.
                    if (wg0_c || wg1_c) begin
                        wptr_q <= wg0_c;
                    end
                    if (rg0_c || rg1_c) begin
                        rptr_q <= rg0_c;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dp_arbiter_1024_64.sv
// Directed bench for ram_dp_arbiter_1024_64 with a behavioural RAM; read data is checked by a
// scoreboard monitor that pops expected values whenever a client's rvalid is seen.
module tb_ram_dp_arbiter_1024_64;

    logic        clk;
    logic        reset;
    logic        c0_req, c0_wr, c1_req, c1_wr;
    logic [9:0]  c0_addr, c1_addr;
    logic [63:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [63:0] c0_rdata, c1_rdata;
    logic        init_done;
    logic [9:0]  ram_wr_addr, ram_rd_addr;
    logic [63:0] ram_data_in, ram_data_out;
    logic        ram_write_en, ram_read_en, ram_chip_select;

    logic [63:0] mem [1024];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    int          total = 0;
    int          bad   = 0;

    ram_dp_arbiter_1024_64 dut (
        .clock(clk), .reset(reset),
        .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .init_done(init_done),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr), .ram_data_in(ram_data_in),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_chip_select(ram_chip_select), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM model
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'hA5A5_A5A5_A5A5_A5A5;
        ram_data_out = '0;
    end
    always @(posedge clk) begin
        if (ram_read_en) ram_data_out <= mem[ram_rd_addr];
        if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (c0_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL c0_rvalid_unexpected actual=1 expected=0 rdata=%h", c0_rdata);
            end else begin
                e = q0.pop_front();
                chk("c0_rdata", c0_rdata, e);
            end
        end
        if (c1_rvalid === 1'b1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL c1_rvalid_unexpected actual=1 expected=0 rdata=%h", c1_rdata);
            end else begin
                e = q1.pop_front();
                chk("c1_rdata", c1_rdata, e);
            end
        end
    end

    task automatic drv(input logic r0, input logic w0, input logic [9:0] a0, input logic [63:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [63:0] d1);
        c0_req = r0; c0_wr = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_wr = w1; c1_addr = a1; c1_wdata = d1;
    endtask

    task automatic idle();
        drv(0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
    endtask

    task automatic step(input logic eg0, input logic eg1, input string nm);
        @(negedge clk);
        chk({nm, "_gnt0"}, 64'(c0_gnt), 64'(eg0));
        chk({nm, "_gnt1"}, 64'(c1_gnt), 64'(eg1));
        @(posedge clk); #1;
    endtask

    // Walks the clear sequence while c1 requests a read that must not be granted.
    task automatic run_clear(input int lim, input bit full, input string nm);
        int         n    = 0;
        int         errs = 0;
        logic [9:0] na;
        drv(0, 0, 10'd0, 64'd0, 1, 0, 10'd5, 64'd0);
        while (init_done !== 1'b1 && n < lim) begin
            na = 10'(n);
            @(negedge clk);
            if (ram_write_en !== 1'b1 || ram_wr_addr !== na || ram_data_in !== 64'd0 ||
                c0_gnt !== 1'b0 || c1_gnt !== 1'b0) errs++;
            @(posedge clk); #1;
            n++;
        end
        idle();
        chk({nm, "_walk_errs"}, 64'(errs), 64'd0);
        chk({nm, "_len"}, 64'(n), full ? 64'd1024 : 64'(lim));
        chk({nm, "_init_done"}, 64'(init_done), 64'(full));
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        drv(1, 1, 10'd3, 64'd1, 1, 0, 10'd4, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 64'(c0_gnt), 64'd0);
        chk("rst_gnt1", 64'(c1_gnt), 64'd0);
        chk("rst_wen", 64'(ram_write_en), 64'd0);
        chk("rst_ren", 64'(ram_read_en), 64'd0);
        chk("rst_cs", 64'(ram_chip_select), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rvalid0", 64'(c0_rvalid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: zero fill, then read back a cleared word
        run_clear(2000, 1'b1, "clr1");
        drv(1, 0, 10'd5, 64'd0, 0, 0, 10'd0, 64'd0);
        q0.push_back(64'd0);
        step(1, 0, "t1_rd5");
        idle();
        step(0, 0, "t1_idle");

        // 2: write then read by c0, with RAM port checks in the write cycle
        drv(1, 1, 10'd2, 64'hDEAD_BEEF, 0, 0, 10'd0, 64'd0);
        @(negedge clk);
        chk("t2_wr_addr", 64'(ram_wr_addr), 64'd2);
        chk("t2_wr_data", ram_data_in, 64'hDEAD_BEEF);
        chk("t2_cs", 64'(ram_chip_select), 64'd1);
        @(posedge clk); #1;
        drv(1, 0, 10'd2, 64'd0, 0, 0, 10'd0, 64'd0);
        q0.push_back(64'hDEAD_BEEF);
        step(1, 0, "t2_rd2");
        idle();
        @(negedge clk);
        chk("t2_hold_addr", 64'(ram_wr_addr), 64'd2);
        chk("t2_idle_wen", 64'(ram_write_en), 64'd0);
        @(posedge clk); #1;

        // 3: round-robin; first pass priority back to c0 on both ports
        drv(0, 0, 10'd0, 64'd0, 1, 1, 10'd11, 64'h11);
        step(0, 1, "t3_c1_wr11");
        drv(1, 0, 10'd0, 64'd0, 1, 0, 10'd11, 64'd0);
        drv(0, 0, 10'd0, 64'd0, 1, 0, 10'd11, 64'd0);
        q1.push_back(64'h11);
        step(0, 1, "t3_c1_rd11");
        drv(1, 1, 10'd20, 64'hA0, 1, 1, 10'd21, 64'hA1);
        step(1, 0, "t3_wr_a");
        step(0, 1, "t3_wr_b");
        step(1, 0, "t3_wr_c");
        step(0, 1, "t3_wr_d");
        drv(1, 0, 10'd20, 64'd0, 1, 0, 10'd21, 64'd0);
        q0.push_back(64'hA0); step(1, 0, "t3_rd_a");
        q1.push_back(64'hA1); step(0, 1, "t3_rd_b");
        q0.push_back(64'hA0); step(1, 0, "t3_rd_c");
        q1.push_back(64'hA1); step(0, 1, "t3_rd_d");

        // 4: same-address hazard, read retried next cycle sees the new data
        drv(1, 1, 10'd7, 64'h77, 1, 0, 10'd7, 64'd0);
        step(1, 0, "t4_hazard");
        drv(0, 0, 10'd0, 64'd0, 1, 0, 10'd7, 64'd0);
        q1.push_back(64'h77);
        step(0, 1, "t4_retry");

        // 5: concurrent read and write from different clients, plus top address
        drv(1, 0, 10'd3, 64'd0, 1, 1, 10'd9, 64'h99);
        q0.push_back(64'd0);
        step(1, 1, "t5_both");
        drv(1, 0, 10'd9, 64'd0, 1, 1, 10'd1023, 64'hFF);
        q0.push_back(64'h99);
        step(1, 1, "t5_rd9_wr1023");
        drv(0, 0, 10'd0, 64'd0, 1, 0, 10'd1023, 64'd0);
        q1.push_back(64'hFF);
        step(0, 1, "t5_rd1023");
        idle();
        step(0, 0, "t5_idle");

        // 6: reset mid-clear restarts the walk; reset after a read grant kills rvalid
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_clear(500, 1'b0, "clr2_partial");
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_wen", 64'(ram_write_en), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_clear(2000, 1'b1, "clr3");
        drv(1, 0, 10'd2, 64'd0, 0, 0, 10'd0, 64'd0);
        q0.push_back(64'd0);
        step(1, 0, "t6_rd2_cleared");
        idle();
        step(0, 0, "t6_idle");
        drv(1, 0, 10'd2, 64'd0, 0, 0, 10'd0, 64'd0);
        step(1, 0, "t6_rd_before_rst");
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rvalid_dropped", 64'(c0_rvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_rvalid_still_low", 64'(c0_rvalid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
